// File: rtl/sl_pkg.sv
// Shared types and default timing constants for the SL line transmitter.
package sl_pkg;

    localparam int SL_PULSE_LEN = 16;
    localparam int SL_SPACE_LEN = 16;
    localparam int SL_GAP_LEN   = 16;
    localparam int SL_MIN_LEN   = 8;
    localparam int SL_MAX_LEN   = 32;
    localparam int SL_TIMER_W   = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BIT_LO,
        ST_BIT_HI,
        ST_PAR_LO,
        ST_PAR_HI,
        ST_STOP_LO,
        ST_STOP_HI,
        ST_GAP
    } sl_tx_state_e;

    // Symbol encoding shared with the receiver side.
    typedef enum logic [1:0] {
        SYM_ZERO,
        SYM_ONE,
        SYM_STOP,
        SYM_IDLE
    } sl_sym_e;

    // Line levels {sl1, sl0} for a symbol; a low level marks the symbol.
    function automatic logic [1:0] sym_to_lines(sl_sym_e sym);
        logic [1:0] lines;
        case (sym)
            SYM_ZERO: lines = 2'b10;
            SYM_ONE:  lines = 2'b01;
            SYM_STOP: lines = 2'b00;
            default:  lines = 2'b11;
        endcase
        return lines;
    endfunction

endpackage

// File: rtl/sl_tx_timer.sv
// Loadable down-counter for phase timing; holds at zero, where tc is high.
module sl_tx_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    logic [WIDTH-1:0] count_q;

    // Reload on phase entry, otherwise count down and saturate at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (count_q != '0) begin
            count_q <= count_q - WIDTH'(1);
        end
    end

    assign count = count_q;
    assign tc    = (count_q == '0);

endmodule

// File: rtl/sl_transmitter.sv
// Serialises a parallel word onto the two-wire SL line: LSB-first data
// symbols, an odd-parity symbol, a stop symbol, then an idle gap.
//
//  state      | meaning
//  -----------+-----------------------------------------------
//  ST_IDLE    | lines high, ready for a word
//  ST_BIT_LO  | line chosen by the current data bit held low
//  ST_BIT_HI  | both lines high after a data symbol
//  ST_PAR_LO  | line chosen by the parity bit held low
//  ST_PAR_HI  | both lines high after the parity symbol
//  ST_STOP_LO | both lines low (stop symbol)
//  ST_STOP_HI | both lines high after the stop symbol
//  ST_GAP     | idle gap; tx_done on its last cycle
module sl_transmitter
    import sl_pkg::*;
#(
    parameter int PULSE_LEN = SL_PULSE_LEN,
    parameter int SPACE_LEN = SL_SPACE_LEN,
    parameter int GAP_LEN   = SL_GAP_LEN,
    parameter int MIN_LEN   = SL_MIN_LEN,
    parameter int MAX_LEN   = SL_MAX_LEN
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] tx_data,
    input  logic [5:0]  tx_len,
    input  logic        tx_inj_par,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic        sl0,
    output logic        sl1,
    output logic        tx_busy,
    output logic        tx_done,
    output logic        len_err
);

    localparam int TW = SL_TIMER_W;

    sl_tx_state_e    state_q, state_d;
    logic [31:0]     shift_q;
    logic [5:0]      len_q;
    logic [4:0]      bit_idx_q;
    logic            par_acc_q;
    logic            inj_q;

    logic            tmr_load;
    logic [TW-1:0]   tmr_val;
    logic [TW-1:0]   tmr_count;
    logic            tmr_tc;

    logic            accept;
    logic            len_ok;
    logic            last_bit;
    logic            bit_next;
    logic            par_bit;
    logic            done_d;
    sl_sym_e         sym_d;
    logic [1:0]      lines_d;

    logic            sl0_q, sl1_q, ready_q, busy_q, done_q, len_err_q;

    sl_tx_timer #(.WIDTH(TW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .count    (tmr_count),
        .tc       (tmr_tc)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, phase timer reloads and the symbol to present next cycle.
    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        accept   = tx_valid && ready_q;
        len_ok   = (tx_len >= 6'(MIN_LEN)) && (tx_len <= 6'(MAX_LEN));
        last_bit = ({1'b0, bit_idx_q} >= (len_q - 6'd1));
        par_bit  = ~par_acc_q ^ inj_q;

        case (state_q)
            ST_IDLE: begin
                if (accept && len_ok) begin
                    state_d  = ST_BIT_LO;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(PULSE_LEN - 1);
                end
            end
            ST_BIT_LO: begin
                if (tmr_tc) begin
                    state_d  = ST_BIT_HI;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(SPACE_LEN - 1);
                end
            end
            ST_BIT_HI: begin
                if (tmr_tc) begin
                    state_d  = last_bit ? ST_PAR_LO : ST_BIT_LO;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(PULSE_LEN - 1);
                end
            end
            ST_PAR_LO: begin
                if (tmr_tc) begin
                    state_d  = ST_PAR_HI;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(SPACE_LEN - 1);
                end
            end
            ST_PAR_HI: begin
                if (tmr_tc) begin
                    state_d  = ST_STOP_LO;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(PULSE_LEN - 1);
                end
            end
            ST_STOP_LO: begin
                if (tmr_tc) begin
                    state_d  = ST_STOP_HI;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(SPACE_LEN - 1);
                end
            end
            ST_STOP_HI: begin
                if (tmr_tc) begin
                    state_d  = ST_GAP;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(GAP_LEN - 1);
                end
            end
            ST_GAP: begin
                if (tmr_tc) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // The shift register advances on the same edge that enters BIT_LO,
        // so look at the bit that will be current after that edge.
        case (state_q)
            ST_IDLE:   bit_next = tx_data[0];
            ST_BIT_HI: bit_next = shift_q[1];
            default:   bit_next = shift_q[0];
        endcase

        case (state_d)
            ST_BIT_LO:  sym_d = bit_next ? SYM_ONE : SYM_ZERO;
            ST_PAR_LO:  sym_d = par_bit ? SYM_ONE : SYM_ZERO;
            ST_STOP_LO: sym_d = SYM_STOP;
            default:    sym_d = SYM_IDLE;
        endcase
        lines_d = sym_to_lines(sym_d);

        // Registered so that tx_done is high during the last GAP cycle.
        done_d = ((state_q == ST_GAP) && (tmr_count == TW'(1)))
              || ((state_q == ST_STOP_HI) && tmr_tc && (GAP_LEN == 1));
    end

    // Word latch, shift register, bit index and serial parity accumulator.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_q   <= '0;
            len_q     <= '0;
            bit_idx_q <= '0;
            par_acc_q <= 1'b0;
            inj_q     <= 1'b0;
        end else if ((state_q == ST_IDLE) && accept && len_ok) begin
            shift_q   <= tx_data;
            len_q     <= tx_len;
            bit_idx_q <= '0;
            par_acc_q <= 1'b0;
            inj_q     <= tx_inj_par;
        end else begin
            if ((state_q == ST_BIT_LO) && tmr_tc) begin
                par_acc_q <= par_acc_q ^ shift_q[0];
            end
            if ((state_q == ST_BIT_HI) && tmr_tc && !last_bit) begin
                shift_q   <= {1'b0, shift_q[31:1]};
                bit_idx_q <= bit_idx_q + 5'd1;
            end
        end
    end

    // Output registers, driven from the next-state view so they line up with the FSM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sl0_q     <= 1'b1;
            sl1_q     <= 1'b1;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            len_err_q <= 1'b0;
        end else begin
            sl0_q     <= lines_d[0];
            sl1_q     <= lines_d[1];
            ready_q   <= (state_d == ST_IDLE) && !accept;
            busy_q    <= (state_d != ST_IDLE);
            done_q    <= done_d;
            len_err_q <= accept && !len_ok;
        end
    end

    assign sl0      = sl0_q;
    assign sl1      = sl1_q;
    assign tx_ready = ready_q;
    assign tx_busy  = busy_q;
    assign tx_done  = done_q;
    assign len_err  = len_err_q;

endmodule

// File: tb/tb_sl_transmitter.sv
// Directed bench for sl_transmitter: decodes the line symbol by symbol and
// checks data, parity, stop, timing, illegal lengths and mid-word reset.
module tb_sl_transmitter;

    logic        clk;
    logic        reset;
    logic [31:0] tx_data;
    logic [5:0]  tx_len;
    logic        tx_inj_par;
    logic        tx_valid;
    logic        tx_ready;
    logic        sl0;
    logic        sl1;
    logic        tx_busy;
    logic        tx_done;
    logic        len_err;

    int n_checks = 0;
    int n_fail   = 0;

    sl_transmitter dut (
        .clk        (clk),
        .reset      (reset),
        .tx_data    (tx_data),
        .tx_len     (tx_len),
        .tx_inj_par (tx_inj_par),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .sl0        (sl0),
        .sl1        (sl1),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done),
        .len_err    (len_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Send one word and decode it from the line. exp_par is hand-computed.
    // With hold=1 tx_valid stays high and the inputs are scrambled while busy.
    task automatic do_word(input logic [31:0] data, input int len, input logic inj,
                           input logic exp_par, input logic hold, input string tag);
        int          waits;
        int          cyc;
        int          k;
        int          s;
        int          ph;
        int          done_cyc;
        int          done_cnt;
        int          bad_sym;
        int          space_err;
        logic        finished;
        logic        stop_ok;
        logic        rx_par;
        logic        busy1;
        logic        ready1;
        logic        ready_after;
        logic        busy_after;
        logic [63:0] rx;
        logic [63:0] mask;

        @(negedge clk);
        tx_data    = data;
        tx_len     = 6'(len);
        tx_inj_par = inj;
        tx_valid   = 1'b1;
        waits = 0;
        while (!tx_ready && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        check_eq({tag, "_accept_wait"}, 64'(waits), 64'd0);
        @(posedge clk);
        #1;
        if (!hold) tx_valid = 1'b0;

        cyc = 1; done_cyc = 0; done_cnt = 0; bad_sym = 0; space_err = 0;
        finished = 1'b0; stop_ok = 1'b0; rx_par = 1'bx; rx = '0;
        busy1 = 1'b0; ready1 = 1'b1; ready_after = 1'b0; busy_after = 1'b1;
        while (!finished && cyc <= 1500) begin
            k  = cyc - 1;
            s  = k / 32;
            ph = k % 32;
            if (cyc == 1) begin
                busy1  = tx_busy;
                ready1 = tx_ready;
            end
            if (s < len + 2 && ph == 8) begin
                if (s == len + 1) begin
                    stop_ok = (sl0 == 1'b0) && (sl1 == 1'b0);
                end else if (sl0 == 1'b0 && sl1 == 1'b1) begin
                    if (s < len) rx[s] = 1'b0; else rx_par = 1'b0;
                end else if (sl0 == 1'b1 && sl1 == 1'b0) begin
                    if (s < len) rx[s] = 1'b1; else rx_par = 1'b1;
                end else begin
                    bad_sym++;
                end
            end
            if ((s < len + 2 && ph == 24) || (s == len + 2 && ph == 8)) begin
                if (!(sl0 && sl1)) space_err++;
            end
            if (tx_done) begin
                if (done_cyc == 0) done_cyc = cyc;
                done_cnt++;
            end
            if (done_cyc != 0 && cyc == done_cyc + 1) begin
                ready_after = tx_ready;
                busy_after  = tx_busy;
                finished    = 1'b1;
            end
            if (hold && cyc == 50) begin
                tx_data    = ~data;
                tx_len     = 6'd9;
                tx_inj_par = ~inj;
            end
            if (!finished) begin
                @(posedge clk);
                #1;
                cyc++;
            end
        end

        mask = (64'd1 << len) - 64'd1;
        check_eq({tag, "_data"},      rx, {32'd0, data} & mask);
        check_eq({tag, "_parity"},    64'(rx_par), 64'(exp_par));
        check_eq({tag, "_stop"},      64'(stop_ok), 64'd1);
        check_eq({tag, "_bad_sym"},   64'(bad_sym), 64'd0);
        check_eq({tag, "_space"},     64'(space_err), 64'd0);
        check_eq({tag, "_done_cyc"},  64'(done_cyc), 64'((len + 2) * 32 + 16));
        check_eq({tag, "_done_cnt"},  64'(done_cnt), 64'd1);
        check_eq({tag, "_busy1"},     64'(busy1), 64'd1);
        check_eq({tag, "_ready1"},    64'(ready1), 64'd0);
        check_eq({tag, "_ready_end"}, 64'(ready_after), 64'd1);
        check_eq({tag, "_busy_end"},  64'(busy_after), 64'd0);
    endtask

    task automatic do_illegal(input logic [5:0] len, input string tag);
        int lows;
        @(negedge clk);
        tx_data    = 32'hFFFF_FFFF;
        tx_len     = len;
        tx_inj_par = 1'b0;
        tx_valid   = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        check_eq({tag, "_len_err"}, 64'(len_err), 64'd1);
        check_eq({tag, "_busy"},    64'(tx_busy), 64'd0);
        lows = 0;
        if (!(sl0 && sl1)) lows++;
        @(posedge clk);
        #1;
        check_eq({tag, "_len_err_clr"}, 64'(len_err), 64'd0);
        check_eq({tag, "_ready2"},      64'(tx_ready), 64'd1);
        for (int i = 0; i < 40; i++) begin
            if (!(sl0 && sl1) || tx_busy) lows++;
            @(posedge clk);
            #1;
        end
        check_eq({tag, "_line_idle"}, 64'(lows), 64'd0);
    endtask

    initial begin
        int dones;
        reset      = 1'b1;
        tx_data    = '0;
        tx_len     = 6'd16;
        tx_inj_par = 1'b0;
        tx_valid   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_sl0",     64'(sl0), 64'd1);
        check_eq("rst_sl1",     64'(sl1), 64'd1);
        check_eq("rst_ready",   64'(tx_ready), 64'd1);
        check_eq("rst_busy",    64'(tx_busy), 64'd0);
        check_eq("rst_done",    64'(tx_done), 64'd0);
        check_eq("rst_len_err", 64'(len_err), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);

        // A5C3 has 8 ones -> parity 1 on sl1.
        do_word(32'h0000_A5C3, 16, 1'b0, 1'b1, 1'b0, "w16");
        // 32 ones -> parity 1; 31 ones -> parity 0.
        do_word(32'hFFFF_FFFF, 32, 1'b0, 1'b1, 1'b0, "w32_ones");
        do_word(32'h7FFF_FFFF, 32, 1'b0, 1'b0, 1'b0, "w32_odd");
        // Low byte 01 (upper bits ignored): natural parity 0, injected -> 1.
        do_word(32'hFFFF_FF01, 8, 1'b1, 1'b1, 1'b0, "w8_inj");
        // 07 has 3 ones -> parity 0 on sl0.
        do_word(32'h0000_0007, 8, 1'b0, 1'b0, 1'b0, "w8_par0");

        do_illegal(6'd7,  "len7");
        do_illegal(6'd33, "len33");

        // Reset at cycle 100 of a len=16 word: symbol 3 (bit 0) is low on sl0.
        @(negedge clk);
        tx_data    = 32'h0000_A5C3;
        tx_len     = 6'd16;
        tx_inj_par = 1'b0;
        tx_valid   = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        repeat (99) @(posedge clk);
        #1;
        check_eq("rst_mid_pre_sl0", 64'(sl0), 64'd0);
        #2;
        reset = 1'b1;
        #1;
        check_eq("rst_mid_sl0",   64'(sl0), 64'd1);
        check_eq("rst_mid_sl1",   64'(sl1), 64'd1);
        check_eq("rst_mid_busy",  64'(tx_busy), 64'd0);
        check_eq("rst_mid_ready", 64'(tx_ready), 64'd1);
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        for (int i = 0; i < 620; i++) begin
            @(posedge clk);
            #1;
            if (tx_done || tx_busy) dones++;
        end
        check_eq("rst_mid_no_done", 64'(dones), 64'd0);
        do_word(32'h0000_A5C3, 16, 1'b0, 1'b1, 1'b0, "post_rst");

        // Back-to-back: valid held through the first word with scrambled
        // inputs; second word must be taken on the first ready cycle.
        // 0x234 (12 bits) has 4 ones -> 1; 0x83 has 3 ones -> 0.
        do_word(32'h0000_1234, 12, 1'b0, 1'b1, 1'b1, "b2b_1");
        do_word(32'h0000_0083, 8, 1'b0, 1'b0, 1'b0, "b2b_2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
